// File: rtl/seq_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM state encodings
// and default sizing of the pattern, length and repeat-count fields.
package seq_tx_pkg;

    localparam int SEQ_TX_WIDTH = 6;  // max pattern length in bits
    localparam int SEQ_TX_LEN_W = 3;  // $clog2(SEQ_TX_WIDTH+1)
    localparam int SEQ_TX_CNT_W = 4;  // repeat counter width

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2,
        ST_DONE  = 2'd3
    } seq_tx_state_t;

endpackage

// File: rtl/seq_tx_shifter.sv
// Loadable shift register for the pattern transmitter. On load the pattern is
// normalised so bit 0 is always the first bit to send (msb_first handled here),
// and a copy is kept so each repeat iteration can restart from it.
// bit_o is the bit the top should register onto dout for the current operation.
module seq_tx_shifter
    import seq_tx_pkg::*;
#(
    parameter int WIDTH = SEQ_TX_WIDTH,
    parameter int LEN_W = SEQ_TX_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             reload_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] pattern_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             msb_first_i,
    output logic             bit_o,
    output logic             parity_o
);

    logic [WIDTH-1:0] norm;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] sr_q;
    int               len_int;

    // Reorder pattern[len-1:0] into send order; unused upper bits are zero.
    always_comb begin
        norm    = '0;
        len_int = int'(len_i);
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                if (i < len_int &&
                    ((msb_first_i && j == len_int - 1 - i) || (!msb_first_i && j == i))) begin
                    norm[i] = pattern_i[j];
                end
            end
        end
    end

    // Bit to emit: first bit of a fresh load, first bit of a repeat, or next bit.
    always_comb begin
        if (load_i)        bit_o = norm[0];
        else if (reload_i) bit_o = cap_q[0];
        else               bit_o = sr_q[0];
    end

    // Even parity over one iteration; masked-off bits are zero so they do not count.
    assign parity_o = ^cap_q;

    // Capture and shift; the emitted bit leaves the register on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_q <= '0;
            sr_q  <= '0;
        end else if (load_i) begin
            cap_q <= norm;
            sr_q  <= norm >> 1;
        end else if (reload_i) begin
            sr_q  <= cap_q >> 1;
        end else if (shift_i) begin
            sr_q  <= sr_q >> 1;
        end
    end

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a captured pattern out one bit per clock,
// optionally repeated back-to-back, then pulses done for one cycle.
// Build option: define SEQ_TX_PARITY_EN to append an even-parity bit after
// every iteration (not for len==0).
// Handshake: start is sampled only in IDLE; the first bit appears on dout the
// cycle after acceptance, and dout_vld marks each cycle dout carries a bit.
module seq_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter int WIDTH = SEQ_TX_WIDTH,
    parameter int LEN_W = SEQ_TX_LEN_W,
    parameter int CNT_W = SEQ_TX_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic             msb_first,
    output logic             dout,
    output logic             dout_vld,
    output logic             busy,
    output logic             done
);

    seq_tx_state_t    state_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] bit_cnt_q;
    logic [CNT_W-1:0] rep_q;
    logic             dout_q;
    logic             vld_q;
    logic             busy_q;
    logic             done_q;

    logic [LEN_W-1:0] len_eff;
    logic             last_bit;
    logic             sh_load;
    logic             sh_reload;
    logic             sh_shift;
    logic             sh_bit;
    logic             sh_par;

    assign len_eff  = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
    assign last_bit = (bit_cnt_q == len_q - LEN_W'(1));

`ifndef SEQ_TX_PARITY_EN
    logic unused_par;
    assign unused_par = sh_par;
`endif

    // Shifter control derived from the current state and counters.
    always_comb begin
        sh_load   = 1'b0;
        sh_reload = 1'b0;
        sh_shift  = 1'b0;
        case (state_q)
            ST_IDLE:  sh_load = start;
            ST_SHIFT: begin
                if (!last_bit) begin
                    sh_shift = 1'b1;
                end
`ifndef SEQ_TX_PARITY_EN
                else if (rep_q != '0) begin
                    sh_reload = 1'b1;
                end
`endif
            end
            ST_PAR:   sh_reload = (rep_q != '0);
            default:  ;
        endcase
    end

    seq_tx_shifter #(
        .WIDTH(WIDTH),
        .LEN_W(LEN_W)
    ) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (sh_load),
        .reload_i   (sh_reload),
        .shift_i    (sh_shift),
        .pattern_i  (pattern),
        .len_i      (len_eff),
        .msb_first_i(msb_first),
        .bit_o      (sh_bit),
        .parity_o   (sh_par)
    );

    // Main FSM with registered outputs, counters and abort-capable reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            bit_cnt_q <= '0;
            rep_q     <= '0;
            dout_q    <= 1'b0;
            vld_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        len_q     <= len_eff;
                        rep_q     <= repeat_n;
                        bit_cnt_q <= '0;
                        if (len_eff == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_SHIFT;
                            dout_q  <= sh_bit;
                            vld_q   <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (!last_bit) begin
                        bit_cnt_q <= bit_cnt_q + LEN_W'(1);
                        dout_q    <= sh_bit;
                    end else begin
                        bit_cnt_q <= '0;
`ifdef SEQ_TX_PARITY_EN
                        state_q   <= ST_PAR;
                        dout_q    <= sh_par;
`else
                        if (rep_q != '0) begin
                            rep_q  <= rep_q - CNT_W'(1);
                            dout_q <= sh_bit;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            dout_q  <= 1'b0;
                            vld_q   <= 1'b0;
                            busy_q  <= 1'b0;
                        end
`endif
                    end
                end
                ST_PAR: begin
                    if (rep_q != '0) begin
                        rep_q   <= rep_q - CNT_W'(1);
                        state_q <= ST_SHIFT;
                        dout_q  <= sh_bit;
                    end else begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        dout_q  <= 1'b0;
                        vld_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dout     = dout_q;
    assign dout_vld = vld_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: per-cycle vector table plus hand sequences for
// repeats, reset abort and done timing. Compile with SEQ_TX_PARITY_EN defined
// to match a parity-enabled build.
module tb_seq_pattern_tx;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [5:0] pattern;
    logic [2:0] len;
    logic [3:0] repeat_n;
    logic       msb_first;
    logic       dout, dout_vld, busy, done;
    logic [3:0] outs;

    always #5 clk = ~clk;

    seq_pattern_tx dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pattern  (pattern),
        .len      (len),
        .repeat_n (repeat_n),
        .msb_first(msb_first),
        .dout     (dout),
        .dout_vld (dout_vld),
        .busy     (busy),
        .done     (done)
    );

    assign outs = {dout, dout_vld, busy, done};

    // expected {dout, dout_vld, busy, done}
    localparam logic [3:0] B1 = 4'b1110;
    localparam logic [3:0] B0 = 4'b0110;
    localparam logic [3:0] DN = 4'b0001;
    localparam logic [3:0] ID = 4'b0000;
    localparam logic [5:0] JP = 6'b010101;  // filler inputs that must be ignored

    typedef struct {
        logic       st;
        logic [5:0] pat;
        logic [2:0] ln;
        logic [3:0] rp;
        logic       msb;
        logic [3:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [0:0] exp_q[$];
    int         total = 0;
    int         bad   = 0;

    // ---------------- driver tasks ----------------
    task automatic add(input logic st, input logic [5:0] p, input logic [2:0] l,
                       input logic [3:0] r, input logic m, input logic [3:0] e);
        vec_t v;
        v.st = st; v.pat = p; v.ln = l; v.rp = r; v.msb = m; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic st, input logic [5:0] p, input logic [2:0] l,
                         input logic [3:0] r, input logic m);
        start = st; pattern = p; len = l; repeat_n = r; msb_first = m;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [3:0] act, input logic [3:0] e);
        total++;
        if (act !== e) begin
            bad++;
            $display("FAIL %s: got dout/vld/busy/done=%b expected %b", name, act, e);
        end
    endtask

    // Independent model of the serial stream for a repeated transfer.
    task automatic run_repeat(input string tag, input logic [5:0] p, input logic [2:0] l,
                              input logic [3:0] r, input logic m);
        logic [5:0] tmp;
        logic       bt;
        logic       par;
        logic [0:0] e;
        int         n;
        exp_q.delete();
        for (int it = 0; it <= int'(r); it++) begin
            par = 1'b0;
            for (int b = 0; b < int'(l); b++) begin
                tmp = m ? (p >> (int'(l) - 1 - b)) : (p >> b);
                bt  = tmp[0];
                par = par ^ bt;
                exp_q.push_back(bt);
            end
`ifdef SEQ_TX_PARITY_EN
            exp_q.push_back(par);
`endif
        end
        drive(1'b1, p, l, r, m);
        tick();
        drive(1'b0, JP, 3'd3, 4'd5, ~m);
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("%s bit %0d", tag, n), outs, {e, 3'b110});
            n++;
            if (exp_q.size() > 0) tick();
        end
        tick();
        check({tag, " done"}, outs, DN);
        tick();
        check({tag, " idle"}, outs, ID);
    endtask

    // ---------------- main test ----------------
    initial begin
        int cyc;

        // Block A: case 1, start during busy and during DONE ignored
        add(1, 6'b111000, 3'd6, 4'd0, 1, B1);
        add(1, JP, 3'd3, 4'd5, 0, B1);
        add(0, JP, 3'd3, 4'd5, 0, B1);
        add(0, JP, 3'd3, 4'd5, 0, B0);
        add(0, JP, 3'd3, 4'd5, 0, B0);
        add(0, JP, 3'd3, 4'd5, 0, B0);
`ifdef SEQ_TX_PARITY_EN
        add(0, JP, 3'd3, 4'd5, 0, B1);
`endif
        add(0, JP, 3'd3, 4'd5, 0, DN);
        add(1, JP, 3'd3, 4'd5, 0, ID);
        // Block B: case 3, lsb first, len 4
        add(1, 6'b000111, 3'd4, 4'd0, 0, B1);
        add(0, JP, 3'd3, 4'd5, 1, B1);
        add(0, JP, 3'd3, 4'd5, 1, B1);
        add(0, JP, 3'd3, 4'd5, 1, B0);
`ifdef SEQ_TX_PARITY_EN
        add(0, JP, 3'd3, 4'd5, 1, B1);
`endif
        add(0, JP, 3'd3, 4'd5, 1, DN);
        add(0, JP, 3'd3, 4'd5, 1, ID);
        // Block C: len 0 -> done next cycle, no bits
        add(1, 6'b101010, 3'd0, 4'd3, 1, DN);
        add(0, JP, 3'd3, 4'd5, 0, ID);
        // Block D: len 7 clamps to 6
        add(1, 6'b101101, 3'd7, 4'd0, 1, B1);
        add(0, JP, 3'd3, 4'd5, 0, B0);
        add(0, JP, 3'd3, 4'd5, 0, B1);
        add(0, JP, 3'd3, 4'd5, 0, B1);
        add(0, JP, 3'd3, 4'd5, 0, B0);
        add(0, JP, 3'd3, 4'd5, 0, B1);
`ifdef SEQ_TX_PARITY_EN
        add(0, JP, 3'd3, 4'd5, 0, B0);
`endif
        add(0, JP, 3'd3, 4'd5, 0, DN);
        add(0, JP, 3'd3, 4'd5, 0, ID);
        // Block E: start held high -> re-accepted in the IDLE cycle after DONE
        add(1, 6'b000010, 3'd2, 4'd0, 1, B1);
        add(1, 6'b000010, 3'd2, 4'd0, 1, B0);
`ifdef SEQ_TX_PARITY_EN
        add(1, 6'b000010, 3'd2, 4'd0, 1, B1);
`endif
        add(1, 6'b000010, 3'd2, 4'd0, 1, DN);
        add(1, 6'b000010, 3'd2, 4'd0, 1, ID);
        add(1, 6'b000010, 3'd2, 4'd0, 1, B1);
        add(0, JP, 3'd3, 4'd5, 0, B0);
`ifdef SEQ_TX_PARITY_EN
        add(0, JP, 3'd3, 4'd5, 0, B1);
`endif
        add(0, JP, 3'd3, 4'd5, 0, DN);
        add(0, JP, 3'd3, 4'd5, 0, ID);

        // reset, with start asserted to show reset wins
        rst = 1'b1;
        drive(1'b1, 6'b111111, 3'd6, 4'd0, 1'b1);
        tick();
        tick();
        check("reset state", outs, ID);
        rst = 1'b0;
        drive(1'b0, JP, 3'd3, 4'd5, 1'b0);
        tick();
        check("idle after reset", outs, ID);

        // table
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].st, vecs[i].pat, vecs[i].ln, vecs[i].rp, vecs[i].msb);
            tick();
            check($sformatf("vec %0d", i), outs, vecs[i].exp);
        end
        drive(1'b0, JP, 3'd3, 4'd5, 1'b0);
        tick();

        // case 2: repeat_n=2, three back-to-back iterations
        run_repeat("rep3 msb", 6'b111000, 3'd6, 4'd2, 1'b1);
        run_repeat("rep2 lsb", 6'b011001, 3'd3, 4'd1, 1'b0);

        // case 5: reset mid-transfer aborts; new start afterwards works
        drive(1'b1, 6'b111000, 3'd6, 4'd0, 1'b1);
        tick();
        check("abort c1", outs, B1);
        drive(1'b0, JP, 3'd3, 4'd5, 1'b0);
        tick();
        check("abort c2", outs, B1);
        tick();
        check("abort c3", outs, B1);
        rst   = 1'b1;
        start = 1'b1;
        tick();
        check("abort c4", outs, ID);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        check("abort c5", outs, ID);
        drive(1'b1, 6'b000111, 3'd4, 4'd0, 1'b0);
        tick();
        check("abort c6 first bit", outs, B1);
        drive(1'b0, JP, 3'd3, 4'd5, 1'b1);
        cyc = 0;
        while (!done && cyc < 30) begin
            tick();
            cyc++;
        end
        check("abort restart done", {3'b000, done}, 4'b0001);
        tick();
        check("abort final idle", outs, ID);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global time limit
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
